// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle multiply/divide unit: one shift-add / restoring-subtract iteration per clock,
// sign correction on a final FIX cycle, Start/Busy/Done handshake.
module iterative_muldiv_unit #(
  parameter int DataWidth = 16,
  parameter bit SignedOps = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [DataWidth-1:0] inSrc_i,
  input  logic [DataWidth-1:0] inDest_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DataWidth-1:0] outDest_o,
  output logic                 outZero_o,
  output logic                 outNegative_o,
  output logic                 outParity_o,
  output logic                 outOverflow_o,
  output logic                 divByZero_o
);

  localparam int W  = DataWidth;
  localparam int CW = $clog2(W);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]    state_q,   state_d;
  logic [CW-1:0] count_q,   count_d;
  logic [1:0]    op_q,      op_d;
  logic [W-1:0]  oper_q,    oper_d;
  logic [W-1:0]  accHi_q,   accHi_d;
  logic [W-1:0]  accLo_q,   accLo_d;
  logic          negRes_q,  negRes_d;
  logic          negRem_q,  negRem_d;
  logic          divZero_q, divZero_d;
  logic          divOvf_q,  divOvf_d;
  logic [W-1:0]  res_q,     res_d;
  logic          ovf_q,     ovf_d;
  logic          dbz_q,     dbz_d;

  logic          accept;
  logic          srcNeg, destNeg;
  logic [W-1:0]  srcMag, destMag;
  logic [W:0]    mulSum;
  logic [W:0]    divShifted;
  logic [W:0]    divDiff;
  logic          divGe;
  logic [2*W-1:0] prod, prodFix;
  logic [W-1:0]  quoFix, remFix;

  assign accept  = start_i && (state_q == StIdle || state_q == StDone);
  assign srcNeg  = SignedOps && inSrc_i[W-1];
  assign destNeg = SignedOps && inDest_i[W-1];
  assign srcMag  = srcNeg  ? -inSrc_i  : inSrc_i;
  assign destMag = destNeg ? -inDest_i : inDest_i;

  // Multiply: accLo holds the multiplier and shifts right as product bits arrive in accHi.
  // Divide: accHi is the partial remainder, accLo the dividend turning into the quotient.
  assign mulSum     = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, oper_q} : {(W+1){1'b0}});
  assign divShifted = {accHi_q, accLo_q[W-1]};
  assign divGe      = divShifted >= {1'b0, oper_q};
  assign divDiff    = divShifted - {1'b0, oper_q};

  assign prod    = {accHi_q, accLo_q};
  assign prodFix = negRes_q ? -prod : prod;
  assign quoFix  = negRes_q ? -accLo_q : accLo_q;
  assign remFix  = negRem_q ? -accHi_q : accHi_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    oper_d    = oper_q;
    accHi_d   = accHi_q;
    accLo_d   = accLo_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    divOvf_d  = divOvf_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    if (accept) begin
      state_d   = StRun;
      count_d   = '0;
      op_d      = op_i;
      oper_d    = op_i[1] ? srcMag : destMag;
      accHi_d   = '0;
      accLo_d   = op_i[1] ? destMag : srcMag;
      negRes_d  = srcNeg ^ destNeg;
      negRem_d  = destNeg;
      divZero_d = (inSrc_i == '0);
      divOvf_d  = SignedOps && (inDest_i == {1'b1, {(W-1){1'b0}}}) && (inSrc_i == '1);
    end else begin
      case (state_q)
        StRun: begin
          if (op_q[1]) begin
            accHi_d = divGe ? divDiff[W-1:0] : divShifted[W-1:0];
            accLo_d = {accLo_q[W-2:0], divGe};
          end else begin
            accHi_d = mulSum[W:1];
            accLo_d = {mulSum[0], accLo_q[W-1:1]};
          end
          if (count_q == CW'(W-1)) begin
            state_d = StFix;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        StFix: begin
          state_d = StDone;
          dbz_d   = op_q[1] && divZero_q;
          case (op_q)
            2'b00: begin
              res_d = prodFix[W-1:0];
              ovf_d = SignedOps ? (prodFix[2*W-1:W] != {W{prodFix[W-1]}})
                                : (prodFix[2*W-1:W] != '0);
            end
            2'b01: begin
              res_d = prodFix[2*W-1:W];
              ovf_d = 1'b0;
            end
            2'b10: begin
              res_d = divZero_q ? '1 : quoFix;
              ovf_d = divOvf_q;
            end
            2'b11: begin
              res_d = remFix;
              ovf_d = divOvf_q;
            end
          endcase
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      count_q   <= '0;
      op_q      <= '0;
      oper_q    <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      divOvf_q  <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      oper_q    <= oper_d;
      accHi_q   <= accHi_d;
      accLo_q   <= accLo_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      divOvf_q  <= divOvf_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy_o        = (state_q == StRun) || (state_q == StFix);
  assign done_o        = (state_q == StDone);
  assign outDest_o     = res_q;
  assign outZero_o     = (res_q == '0);
  assign outNegative_o = SignedOps && res_q[W-1];
  assign outParity_o   = ~^res_q;
  assign outOverflow_o = ovf_q;
  assign divByZero_o   = dbz_q;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Scoreboard bench for iterative_muldiv_unit: a signed and an unsigned instance (W=16),
// directed vectors with hand-computed results, latency checked against the acceptance edge.
module tb_iterative_muldiv_unit;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         neg;
    logic         ovf;
    logic         dbz;
    int           acceptEdge;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         startS = 1'b0;
  logic         startU = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src = '0;
  logic [W-1:0] dest = '0;

  logic         sBusy, sDone, sZero, sNeg, sPar, sOvf, sDbz;
  logic [W-1:0] sOut;
  logic         uBusy, uDone, uZero, uNeg, uPar, uOvf, uDbz;
  logic [W-1:0] uOut;

  int   edgeCnt = 0;
  int   passCount = 0;
  int   totalCount = 0;
  exp_t qS[$];
  exp_t qU[$];

  iterative_muldiv_unit #(.DataWidth(W), .SignedOps(1'b1)) dutS (
    .clk_i(clk), .rst_i(rst), .start_i(startS), .op_i(op), .inSrc_i(src), .inDest_i(dest),
    .busy_o(sBusy), .done_o(sDone), .outDest_o(sOut), .outZero_o(sZero),
    .outNegative_o(sNeg), .outParity_o(sPar), .outOverflow_o(sOvf), .divByZero_o(sDbz)
  );

  iterative_muldiv_unit #(.DataWidth(W), .SignedOps(1'b0)) dutU (
    .clk_i(clk), .rst_i(rst), .start_i(startU), .op_i(op), .inSrc_i(src), .inDest_i(dest),
    .busy_o(uBusy), .done_o(uDone), .outDest_o(uOut), .outZero_o(uZero),
    .outNegative_o(uNeg), .outParity_o(uPar), .outOverflow_o(uOvf), .divByZero_o(uDbz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    totalCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  task automatic compareEntry(input exp_t e, input logic [W-1:0] out,
                              input logic [4:0] flags);
    checkOutput({e.name, " result"}, 32'(out), 32'(e.res));
    checkOutput({e.name, " flags{zero,neg,par,ovf,dbz}"}, 32'(flags),
                32'({e.res == '0, e.neg, ~^e.res, e.ovf, e.dbz}));
    checkOutput({e.name, " done edge"}, 32'(edgeCnt), 32'(e.acceptEdge + W + 1));
  endtask

  // Monitors: every Done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && sDone) begin
      if (qS.size() == 0) begin
        totalCount++;
        $display("[TB] FAIL unexpected signed Done: actual=%h required=none", sOut);
      end else begin
        compareEntry(qS.pop_front(), sOut, {sZero, sNeg, sPar, sOvf, sDbz});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && uDone) begin
      if (qU.size() == 0) begin
        totalCount++;
        $display("[TB] FAIL unexpected unsigned Done: actual=%h required=none", uOut);
      end else begin
        compareEntry(qU.pop_front(), uOut, {uZero, uNeg, uPar, uOvf, uDbz});
      end
    end
  end

  // Waits for the chosen unit to be free, then issues one op; returns on the negedge after acceptance.
  task automatic applyStimulus(input bit uns, input logic [1:0] o, input logic [W-1:0] d,
                               input logic [W-1:0] s, input string name,
                               input logic [W-1:0] res, input logic neg, input logic ovf,
                               input logic dbz);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while ((uns ? uBusy : sBusy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (uns ? uBusy : sBusy) begin
      totalCount++;
      $display("[TB] FAIL %s busy timeout: actual=busy required=idle", name);
    end
    op   = o;
    dest = d;
    src  = s;
    if (uns) startU = 1'b1;
    else     startS = 1'b1;
    e.res = res; e.neg = neg; e.ovf = ovf; e.dbz = dbz;
    e.acceptEdge = edgeCnt + 1;
    e.name = name;
    if (uns) qU.push_back(e);
    else     qS.push_back(e);
    @(negedge clk);
    startS = 1'b0;
    startU = 1'b0;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " signed outputs"}, 32'({sBusy, sDone, sOut, sZero, sNeg, sPar, sOvf, sDbz}),
                32'({2'b00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((qS.size() != 0 || qU.size() != 0 || sBusy || uBusy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      totalCount++;
      $display("[TB] FAIL %s drain timeout: actual=%0d pending required=0", name, qS.size() + qU.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Outputs are zero under reset; Zero and Parity follow from OutDest==0.
    repeat (3) @(negedge clk);
    checkOutput("reset busy/done/result", 32'({sBusy, sDone, sOut}), 32'h0);
    checkOutput("reset ovf/dbz/neg", 32'({sOvf, sDbz, sNeg}), 32'h0);
    rst = 1'b0;

    // Back-to-back sequence: each follow-on op is issued in the previous op's Done cycle.
    applyStimulus(0, 2'b00, 16'd300,  16'hFFF9, "MUL 300*-7",       16'hF7CC, 1, 0, 0);
    applyStimulus(0, 2'b01, 16'd300,  16'hFFF9, "MUH 300*-7",       16'hFFFF, 1, 0, 0);
    applyStimulus(0, 2'b10, 16'hFFF9, 16'd2,    "DIV -7/2",         16'hFFFD, 1, 0, 0);
    applyStimulus(0, 2'b11, 16'hFFF9, 16'd2,    "MOD -7/2",         16'hFFFF, 1, 0, 0);
    applyStimulus(0, 2'b10, 16'h1234, 16'h0000, "DIV by zero",      16'hFFFF, 1, 0, 1);
    applyStimulus(0, 2'b11, 16'h1234, 16'h0000, "MOD by zero",      16'h1234, 0, 0, 1);
    applyStimulus(0, 2'b10, 16'h8000, 16'hFFFF, "DIV min/-1",       16'h8000, 1, 1, 0);
    applyStimulus(0, 2'b11, 16'h8000, 16'hFFFF, "MOD min/-1",       16'h0000, 0, 1, 0);
    applyStimulus(0, 2'b00, 16'd300,  16'd300,  "MUL 300*300 ovf",  16'h5F90, 0, 1, 0);
    applyStimulus(0, 2'b00, 16'hFED4, 16'hFFF9, "MUL -300*-7",      16'h0834, 0, 0, 0);
    drain("signed sequence");

    // Start pulses during edges 3..10 of an op must be ignored.
    applyStimulus(0, 2'b00, 16'd300, 16'hFFF9, "MUL with ignored starts", 16'hF7CC, 1, 0, 0);
    repeat (2) @(negedge clk);
    op = 2'b10; dest = 16'h5555; src = 16'h0003; startS = 1'b1;
    repeat (8) @(negedge clk);
    startS = 1'b0;
    drain("ignored starts");

    // Reset five edges into a MUL: outputs drop at once and no Done follows.
    applyStimulus(0, 2'b00, 16'd300, 16'hFFF9, "MUL aborted", 16'hF7CC, 1, 0, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1 checkAllZero("mid-op reset");
    qS.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("no Done after reset", 32'({sBusy, sDone, sOut}), 32'h0);
    applyStimulus(0, 2'b00, 16'd5, 16'd6, "MUL 5*6 after reset", 16'h001E, 0, 0, 0);
    drain("after reset");

    // Unsigned instance.
    applyStimulus(1, 2'b01, 16'hFFFF, 16'hFFFF, "uMUH FFFF*FFFF", 16'hFFFE, 0, 0, 0);
    applyStimulus(1, 2'b00, 16'hFFFF, 16'hFFFF, "uMUL FFFF*FFFF", 16'h0001, 0, 1, 0);
    applyStimulus(1, 2'b10, 16'hFFF9, 16'd2,    "uDIV FFF9/2",    16'h7FFC, 0, 0, 0);
    drain("unsigned");

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
